// File: rtl/ir_command_controller_pkg.sv
// Shared definitions for the IR command controller: event codes, frame field
// positions, FSM state type and a constant-time clog2 helper.
package ir_command_controller_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_REPEAT  = 2'd1;
  localparam logic [1:0] EVT_RELEASE = 2'd2;

  localparam int CMD_LSB  = 0;
  localparam int CMD_MSB  = 6;
  localparam int ADDR_LSB = 7;
  localparam int ADDR_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input longint value);
    int     r;
    longint v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ir_command_controller_evt_fifo.sv
// Synchronous event FIFO; an extra pointer bit tells full from empty.
// Head data reads as zero while the FIFO is empty.
module ir_evt_fifo
  import ir_command_controller_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ir_command_controller.sv
// Turns decoded IR frames into PRESS / REPEAT / RELEASE key events, queued
// in a small FIFO for the application to drain over valid/ready.
module ir_command_controller
  import ir_command_controller_pkg::*;
#(
  parameter bit         ADDR_FILTER_EN = 1'b1,
  parameter logic [4:0] DEV_ADDR       = 5'd1,
  parameter int         CONFIRM_FRAMES = 2,
  parameter int         REPEAT_FRAMES  = 3,
  parameter int         RELEASE_CYCLES = 5_000_000,
  parameter int         EVT_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ir_data,
  input  logic        ir_data_rdy,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [6:0]  evt_cmd,
  output logic [4:0]  evt_addr,
  output logic        evt_overflow,
  output logic        key_held,
  output logic [6:0]  held_cmd
);

  localparam int             TW         = clog2(RELEASE_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(RELEASE_CYCLES - 1);
  localparam logic [3:0]     CONFIRM_N  = 4'(CONFIRM_FRAMES);
  localparam logic [3:0]     REPEAT_N   = 4'(REPEAT_FRAMES);

  state_t         state, state_nxt;
  logic [11:0]    cand, cand_nxt;
  logic [3:0]     cnt, cnt_nxt, rep, rep_nxt;
  logic [3:0]     cnt_inc, rep_inc;
  logic [TW-1:0]  timer;
  logic           rdy_q, fs, af, same, to;
  logic           evt_push;
  logic [1:0]     evt_kind;
  logic [11:0]    evt_frame;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [13:0]    fifo_din, fifo_dout;

  assign fs      = ir_data_rdy & ~rdy_q;
  assign af      = fs & (!ADDR_FILTER_EN || (ir_data[ADDR_MSB:ADDR_LSB] == DEV_ADDR));
  assign same    = (ir_data == cand);
  assign cnt_inc = cnt + 4'd1;
  assign rep_inc = rep + 4'd1;
  // An accepted frame in the expiry cycle keeps the key alive.
  assign to      = (state != ST_IDLE) && (timer == TIMER_LAST) && !af;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      timer <= '0;
    end else begin
      rdy_q <= ir_data_rdy;
      if (af || state == ST_IDLE) timer <= '0;
      else                        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cand     <= '0;
      cnt      <= '0;
      rep      <= '0;
      key_held <= 1'b0;
      held_cmd <= '0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      rep      <= rep_nxt;
      key_held <= (state_nxt == ST_HELD);
      held_cmd <= (state_nxt == ST_HELD) ? cand_nxt[CMD_MSB:CMD_LSB] : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    rep_nxt   = rep;
    case (state)
      ST_IDLE: if (af) begin
        cand_nxt  = ir_data;
        cnt_nxt   = 4'd1;
        rep_nxt   = '0;
        state_nxt = (CONFIRM_FRAMES == 1) ? ST_HELD : ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (af && same) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CONFIRM_N) begin
            state_nxt = ST_HELD;
            rep_nxt   = '0;
          end
        end else if (af) begin
          cand_nxt = ir_data;
          cnt_nxt  = 4'd1;
        end else if (to) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (af && same) begin
          rep_nxt = (REPEAT_N != 4'd0 && rep_inc == REPEAT_N) ? 4'd0 : rep_inc;
        end else if (af || to) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_push  = 1'b0;
    evt_kind  = EVT_PRESS;
    evt_frame = cand;
    case (state)
      ST_IDLE: if (af && CONFIRM_FRAMES == 1) begin
        evt_push  = 1'b1;
        evt_frame = ir_data;
      end
      ST_CONFIRM: evt_push = af && same && (cnt_inc == CONFIRM_N);
      ST_HELD: begin
        if (af && same) begin
          evt_push = (REPEAT_N != 4'd0) && (rep_inc == REPEAT_N);
          evt_kind = EVT_REPEAT;
        end else if (af || to) begin
          evt_push = 1'b1;
          evt_kind = EVT_RELEASE;
        end
      end
      default: evt_push = 1'b0;
    endcase
  end

  assign fifo_din = {evt_kind, evt_frame[CMD_MSB:CMD_LSB], evt_frame[ADDR_MSB:ADDR_LSB]};
  assign fifo_pop = evt_valid & evt_ready;

  ir_evt_fifo #(
    .WIDTH (14),
    .DEPTH (EVT_FIFO_DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_type  = fifo_dout[13:12];
  assign evt_cmd   = fifo_dout[11:5];
  assign evt_addr  = fifo_dout[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_overflow <= 1'b0;
    else        evt_overflow <= evt_push & fifo_full & ~fifo_pop;
  end

endmodule

// File: tb/tb_ir_command_controller.sv
// Bench for ir_command_controller: directed scenarios plus randomized frames,
// checked against an event-level reference model.
module tb_ir_command_controller;

  localparam int         RC   = 100;
  localparam int         CF   = 2;
  localparam int         RF   = 3;
  localparam logic [4:0] ADDR = 5'd1;
  localparam int         DEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ir_data;
  logic        ir_data_rdy;
  logic        evt_valid, evt_ready, evt_overflow, key_held;
  logic [1:0]  evt_type;
  logic [6:0]  evt_cmd, held_cmd;
  logic [4:0]  evt_addr;

  ir_command_controller #(
    .ADDR_FILTER_EN (1'b1),
    .DEV_ADDR       (ADDR),
    .CONFIRM_FRAMES (CF),
    .REPEAT_FRAMES  (RF),
    .RELEASE_CYCLES (RC),
    .EVT_FIFO_DEPTH (DEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir_data      (ir_data),
    .ir_data_rdy  (ir_data_rdy),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_type     (evt_type),
    .evt_cmd      (evt_cmd),
    .evt_addr     (evt_addr),
    .evt_overflow (evt_overflow),
    .key_held     (key_held),
    .held_cmd     (held_cmd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ovf_cnt = 0;

  logic [13:0] got_q[$];
  int          got_cyc[$];
  logic [13:0] exp_q[$];

  // reference model state: 0 idle, 1 confirming, 2 held
  int          m_state = 0;
  logic [11:0] m_cand = '0;
  int          m_cnt = 0;
  int          m_rep = 0;
  int          m_last = 0;
  bit          m_stall = 0;
  int          m_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      got_q.push_back({evt_type, evt_cmd, evt_addr});
      got_cyc.push_back(cyc);
    end
    if (evt_overflow) ovf_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_push(input logic [1:0] kind);
    // with the consumer stalled, only DEP events fit
    if (m_stall && exp_q.size() >= DEP) m_ovf++;
    else exp_q.push_back({kind, m_cand[6:0], m_cand[11:7]});
  endtask

  task automatic m_timeout(input int now);
    if (m_state != 0 && now - m_last > RC) begin
      if (m_state == 2) m_push(2'd2);
      m_state = 0;
    end
  endtask

  task automatic m_frame(input logic [11:0] f, input int now);
    if (f[11:7] == ADDR) begin
      m_timeout(now);
      m_last = now;
      if (m_state == 0) begin
        m_cand = f; m_cnt = 1; m_rep = 0;
        if (CF == 1) begin m_push(2'd0); m_state = 2; end
        else m_state = 1;
      end else if (m_state == 1) begin
        if (f == m_cand) begin
          m_cnt++;
          if (m_cnt == CF) begin m_push(2'd0); m_state = 2; m_rep = 0; end
        end else begin
          m_cand = f; m_cnt = 1;
        end
      end else begin
        if (f == m_cand) begin
          m_rep++;
          if (RF != 0 && m_rep == RF) begin m_push(2'd1); m_rep = 0; end
        end else begin
          m_push(2'd2);
          m_state = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [11:0] f, input int hold);
    @(negedge clk);
    ir_data = f;
    ir_data_rdy = 1'b1;
    m_frame(f, cyc);
    repeat (hold) @(negedge clk);
    ir_data_rdy = 1'b0;
  endtask

  // next rising edge of ir_data_rdy comes exactly gap cycles after this one
  task automatic frame_gap(input logic [11:0] f, input int gap);
    send_frame(f, 1);
    idle(gap - 2);
  endtask

  task automatic compare_events(input string tag);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_val(tag, got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_hold(input string tag);
    check_val({tag, "_held"}, key_held, (m_state == 2));
    check_val({tag, "_cmd"}, held_cmd, (m_state == 2) ? m_cand[6:0] : 7'd0);
  endtask

  initial begin
    logic [11:0] f;
    int          hold, gap;
    rst_n = 1'b0;
    ir_data = '0;
    ir_data_rdy = 1'b0;
    evt_ready = 1'b1;
    idle(3);
    check_val("rst_valid", evt_valid, 0);
    check_val("rst_head", {evt_type, evt_cmd, evt_addr}, 0);
    check_val("rst_ovf", evt_overflow, 0);
    check_val("rst_held", key_held, 0);
    check_val("rst_held_cmd", held_cmd, 0);
    rst_n = 1'b1;
    idle(2);

    // press with latency probe
    evt_ready = 1'b0;
    frame_gap(12'h095, 40);
    send_frame(12'h095, 2);
    check_val("t1_valid", evt_valid, 1);
    check_val("t1_head", {evt_type, evt_cmd, evt_addr}, {2'd0, 7'h15, 5'd1});
    evt_ready = 1'b1;
    idle(37);
    check_hold("t1");

    // repeats then timeout release
    for (int i = 0; i < 6; i++) frame_gap(12'h095, 40);
    idle(100);
    m_timeout(cyc);
    check_val("t2_rel_cyc", (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : 0,
              m_last + RC + 1);
    compare_events("t2");
    check_hold("t2");

    // foreign address ignored, timer not refreshed
    frame_gap(12'h095, 40);
    frame_gap(12'h095, 20);
    for (int i = 0; i < 3; i++) frame_gap(12'h115, 20);
    idle(100);
    m_timeout(cyc);
    check_val("t3_rel_cyc", (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : 0,
              m_last + RC + 1);
    compare_events("t3");

    // new code releases; it then needs full confirmation
    frame_gap(12'h095, 40);
    frame_gap(12'h095, 40);
    frame_gap(12'h096, 40);
    check_hold("t4_rel");
    frame_gap(12'h096, 40);
    check_val("t4_nopress", got_q.size(), exp_q.size());
    check_hold("t4_second");
    frame_gap(12'h096, 40);
    check_hold("t4_third");
    idle(120);
    m_timeout(cyc);
    compare_events("t4");

    // stalled consumer, overflow
    evt_ready = 1'b0;
    m_stall = 1;
    m_ovf = 0;
    ovf_cnt = 0;
    for (int i = 0; i < 8; i++) frame_gap(12'h095, 30);
    for (int i = 0; i < 3; i++) frame_gap(12'h096, 30);
    check_val("t5_ovf", ovf_cnt, m_ovf);
    check_val("t5_ovf_once", ovf_cnt, 1);
    m_stall = 0;
    evt_ready = 1'b1;
    idle(10);
    compare_events("t5");
    idle(120);
    m_timeout(cyc);
    compare_events("t5_tail");

    // async reset mid-hold with events queued
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) frame_gap(12'h095, 30);
    check_val("t6_pre_valid", evt_valid, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("t6_valid", evt_valid, 0);
    check_val("t6_head", {evt_type, evt_cmd, evt_addr}, 0);
    check_val("t6_held", key_held, 0);
    check_val("t6_held_cmd", held_cmd, 0);
    idle(2);
    rst_n = 1'b1;
    m_state = 0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    evt_ready = 1'b1;
    idle(200);
    compare_events("t6");

    // long ready level counts once
    send_frame(12'h095, 50);
    idle(10);
    check_val("t7_one_frame", got_q.size(), 0);
    check_hold("t7_long");
    frame_gap(12'h095, 20);
    check_hold("t7_second");

    // timer boundary: gap of RC keeps the key, RC+1 releases it
    frame_gap(12'h095, RC);
    check_hold("t8_gap_rc");
    frame_gap(12'h095, RC + 1);
    check_hold("t8_gap_rc1");
    idle(150);
    m_timeout(cyc);
    compare_events("t8");

    // randomized frames
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: f = 12'h095;
        5, 6:          f = 12'h096;
        7:             f = 12'h115;
        8:             f = {ADDR, 7'($urandom_range(0, 127))};
        default:       f = 12'($urandom_range(0, 4095));
      endcase
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 19) < 16) ? $urandom_range(5, 50) : $urandom_range(96, 104);
      send_frame(f, hold);
      if (f[11:7] == ADDR) check_hold("rnd");
      idle(gap - hold - 1);
    end
    idle(150);
    m_timeout(cyc);
    compare_events("rnd");
    check_hold("rnd_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
